// File: rtl/fp_mul_round_pack_pkg.sv
// fp_mul_round_pack_pkg: shared FP32 constants, stage-1 record and operand classifier.
package fp_mul_round_pack_pkg;

    localparam int BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zd;
    } fp_class_t;

    typedef struct packed {
        logic              special;
        logic [31:0]       spec_res;
        logic [2:0]        spec_flags;
        logic              sign;
        logic signed [9:0] exp;
        logic [22:0]       mant;
        logic              guard;
        logic              sticky;
    } s1_t;

    // zd covers zero and denormal operands alike, since denormals are flushed
    function automatic fp_class_t classify(input logic [31:0] x);
        return '{nan: (&x[30:23]) && (|x[22:0]),
                 inf: (&x[30:23]) && !(|x[22:0]),
                 zd:  !(|x[30:23])};
    endfunction

endpackage

// File: rtl/fp_mul_round_pack_round.sv
// fp_round_rne: round-to-nearest-even increment of a 23-bit mantissa.
module fp_round_rne (
    input  logic [22:0] mant,
    input  logic        guard,
    input  logic        sticky,
    output logic [22:0] rounded,
    output logic        carry
);

    assign {carry, rounded} = {1'b0, mant} + 24'(guard && (sticky || mant[0]));

endmodule

// File: rtl/fp_mul_round_pack.sv
// fp_mul_round_pack: two-stage FP32 multiply back end (decode/normalise, then round/pack).
module fp_mul_round_pack
    import fp_mul_round_pack_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [63:0]      in_prod,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_flags
);

    logic              s1_valid;
    logic              s2_adv;
    s1_t               s1;
    s1_t               s1_n;
    logic [TAG_W-1:0]  s1_tag;
    fp_class_t         ca;
    fp_class_t         cb;
    logic [47:0]       prod;
    logic              nan_in;
    logic              inv;
    logic [22:0]       r_mant;
    logic              r_carry;
    logic signed [9:0] e_fin;
    logic              ovf;
    logic              unf;
    logic [31:0]       res;
    logic [2:0]        flags;
    logic              unused_prod;

    assign prod = in_prod[47:0];
    assign unused_prod = ^in_prod[63:48];
    assign ca = classify(in_a);
    assign cb = classify(in_b);
    assign s2_adv = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign nan_in = ca.nan || cb.nan;
    assign inv = !nan_in && ((ca.inf && cb.zd) || (cb.inf && ca.zd));

    always_comb begin
        s1_n = '0;
        s1_n.sign = in_a[31] ^ in_b[31];
        s1_n.special = nan_in || ca.inf || cb.inf || ca.zd || cb.zd;
        s1_n.spec_res = (nan_in || inv) ? CANON_NAN :
                        (ca.inf || cb.inf) ? {s1_n.sign, 8'(EXP_MAX), 23'd0} : {s1_n.sign, 31'd0};
        s1_n.spec_flags = inv ? 3'(1 << FLAG_INV) : 3'd0;
        s1_n.exp = {2'b0, in_a[30:23]} + {2'b0, in_b[30:23]} - 10'(BIAS) + {9'd0, prod[47]};
        s1_n.mant = prod[47] ? prod[46:24] : prod[45:23];
        s1_n.guard = prod[47] ? prod[23] : prod[22];
        s1_n.sticky = prod[47] ? |prod[22:0] : |prod[21:0];
    end

    fp_round_rne u_round (
        .mant   (s1.mant),
        .guard  (s1.guard),
        .sticky (s1.sticky),
        .rounded(r_mant),
        .carry  (r_carry)
    );

    // overflow/underflow are judged on the exponent after any rounding carry
    assign e_fin = s1.exp + {9'd0, r_carry};
    assign ovf = e_fin >= $signed(10'(EXP_MAX));
    assign unf = e_fin <= 10'sd0;
    assign res = s1.special ? s1.spec_res :
                 ovf ? {s1.sign, 8'(EXP_MAX), 23'd0} :
                 unf ? {s1.sign, 31'd0} : {s1.sign, e_fin[7:0], r_mant};
    assign flags = s1.special ? s1.spec_flags :
                   ovf ? 3'(1 << FLAG_OVF) :
                   unf ? 3'(1 << FLAG_UNF) : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1         <= '0;
            s1_tag     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1     <= s1_n;
                    s1_tag <= in_tag;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= res;
                    out_tag    <= s1_tag;
                    out_flags  <= flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// tb_fp_mul_round_pack: directed and random checks of fp_mul_round_pack against an integer reference.
module tb_fp_mul_round_pack;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [63:0]      in_prod = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int ready_mode = 1;
    bit rnd_ready = 1'b1;
    bit lat_mode = 1'b0;

    typedef struct {
        logic [31:0]      res;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_stall = 1'b0;
    logic [31:0] h_res;
    logic [TAG_W-1:0] h_tag;
    logic [2:0] h_flags;

    fp_mul_round_pack #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_prod   (in_prod),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    assign out_ready = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1 rnd_ready = $urandom_range(0, 3) != 0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference: classify by field values, then round the full integer product by remainder.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic [63:0] prod);
        logic s;
        int ea, eb, e, sh;
        bit nan, inv;
        longint unsigned p, q, rem, half;
        s = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0);
        inv = !nan && ((ea == 255 && eb == 0) || (eb == 255 && ea == 0));
        if (nan) return {32'h7FC0_0000, 3'b000};
        if (inv) return {32'h7FC0_0000, 3'b100};
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0, 3'b000};
        if (ea == 0 || eb == 0) return {s, 31'd0, 3'b000};
        p = longint'(prod[47:0]);
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        e = ea + eb - 127 + sh - 23;
        q = p >> sh;
        rem = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q % 2 == 1)) q++;
        if (q >= (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 3'b010};
        if (e <= 0) return {s, 31'd0, 3'b001};
        return {s, 8'(e), 23'(q), 3'b000};
    endfunction

    function automatic logic [63:0] prod_of(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ma, mb;
        ma = {40'd0, a[30:23] != 0, a[22:0]};
        mb = {40'd0, b[30:23] != 0, b[22:0]};
        return ma * mb;
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [7:0] e;
        logic [22:0] f;
        k = $urandom_range(0, 15);
        f = 23'($urandom);
        e = k == 0 ? 8'd0 : k == 1 ? 8'hFF : k == 2 ? 8'($urandom_range(190, 254)) :
            k == 3 ? 8'($urandom_range(1, 64)) : 8'($urandom_range(100, 154));
        if (k <= 1 && $urandom_range(0, 1) == 1) f = '0;
        return {1'($urandom), e, f};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p,
                        input logic [TAG_W-1:0] t, input bit fixed, input logic [34:0] want);
        logic [34:0] m;
        bit acc;
        acc = 1'b0;
        m = fixed ? want : model(a, b, p);
        in_a = a;
        in_b = b;
        in_prod = p;
        in_tag = t;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                exp_q.push_back('{m[34:3], m[2:0], t, cyc});
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall)
                check("hold", {out_valid, out_result, out_tag, out_flags}, {1'b1, h_res, h_tag, h_flags});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("result", out_result, mon_e.res);
                    check("flags", out_flags, mon_e.flags);
                    check("tag", out_tag, mon_e.tag);
                    if (lat_mode) check("latency", 64'(cyc - mon_e.cyc), 64'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            h_res = out_result;
            h_tag = out_tag;
            h_flags = out_flags;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[12];
        int base, c0;
        logic [31:0] a, b;
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 64'h600000000000, 32'h40400000, 3'b000};
        vecs[1]  = '{32'h7F000000, 32'h40000000, 64'h400000000000, 32'h7F800000, 3'b010};
        vecs[2]  = '{32'h7F800000, 32'h00000000, 64'h0,            32'h7FC00000, 3'b100};
        vecs[3]  = '{32'h7FC00001, 32'h3F800000, 64'h0,            32'h7FC00000, 3'b000};
        vecs[4]  = '{32'h3F800001, 32'h3F800001, 64'h400001000001, 32'h3F800002, 3'b000};
        vecs[5]  = '{32'h3FC00000, 32'h3F2AAAAE, 64'h800002800000, 32'h3F800002, 3'b000};
        vecs[6]  = '{32'hFF800000, 32'h40000000, 64'h0,            32'hFF800000, 3'b000};
        vecs[7]  = '{32'h80000000, 32'h40000000, 64'h0,            32'h80000000, 3'b000};
        vecs[8]  = '{32'h3F800000, 32'h3F800000, 64'h7FFFFFC00000, 32'h40000000, 3'b000};
        vecs[9]  = '{32'h7F000000, 32'h3F800000, 64'h7FFFFFC00000, 32'h7F800000, 3'b010};
        vecs[10] = '{32'h00800000, 32'h3F800000, 64'h400000000000, 32'h00800000, 3'b000};
        vecs[11] = '{32'h00800000, 32'h3F000000, 64'h400000000000, 32'h00000000, 3'b001};

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);

        lat_mode = 1'b1;
        ready_mode = 1;
        c0 = cyc;
        for (int i = 0; i < 12; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].p, TAG_W'(i), 1'b1, {vecs[i].res, vecs[i].flags});
        in_valid = 1'b0;
        check("throughput", 64'(cyc - c0), 64'd12);
        drain();

        lat_mode = 1'b0;
        ready_mode = 0;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    a = rand_op();
                    b = rand_op();
                    send(a, b, prod_of(a, b), TAG_W'(8 + i), 1'b0, '0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                check("acc_before_stall", 64'(n_acc - base), 64'd2);
                check("in_ready_stalled", 64'(in_ready), 64'd0);
                @(posedge clk);
                #2;
                check("acc_during_stall", 64'(n_acc - base), 64'd2);
                ready_mode = 1;
            end
        join
        drain();

        ready_mode = 0;
        for (int i = 0; i < 2; i++) begin
            a = 32'h3F800000 | 32'($urandom_range(1, 32'h7FFFFF));
            b = 32'h40000000 | 32'($urandom_range(1, 32'h7FFFFF));
            send(a, b, prod_of(a, b), TAG_W'(5 + i), 1'b0, '0);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_result", 64'(out_result), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        check("midrst_out_flags", 64'(out_flags), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("quiet_after_rst", 64'(out_valid), 64'd0);
        end
        check("ready_after_midrst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(32'h3FC00000, 32'h40000000, 64'h600000000000, TAG_W'(3), 1'b0, '0);
        in_valid = 1'b0;
        drain();

        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            a = rand_op();
            b = rand_op();
            send(a, b, prod_of(a, b), TAG_W'($urandom), 1'b0, '0);
        end
        in_valid = 1'b0;
        ready_mode = 1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
